// File: rtl/fdiv_pkg.sv
// Shared state encoding and defaults for the fdiv clock-divider controller.
// Build option FDIV_PCNT_EN adds a completed-period counter output to fdiv_ctrl.
package fdiv_pkg;

    localparam int unsigned DIV_W_DEF    = 8;
    localparam int unsigned DEF_HALF_DEF = 25;
    localparam int unsigned PCNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } fdiv_state_t;

endpackage

// File: rtl/fdiv_core.sv
// Half-period counter that produces the divided clock, its rising-phase TICK
// and the end-of-full-period boundary flag for the active divisor.
module fdiv_core
    import fdiv_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_active,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_boundary
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap     = i_run && (r_cnt == (i_active - DIV_W'(1)));
    assign o_boundary = w_wrap && r_clk;
    assign o_clk      = r_clk;
    assign o_tick     = r_tick;

    // Not running holds the clock low with the counter parked at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_clk  <= ~r_clk;
            r_tick <= ~r_clk;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/fdiv_ctrl.sv
// Run-time controller for the programmable clock divider: divisor handshake,
// glitch-free divisor swap at period boundaries, clean start/stop. Option: FDIV_PCNT_EN.
module fdiv_ctrl
    import fdiv_pkg::*;
#(
    parameter int unsigned DIV_W    = DIV_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_DEF
) (
    input  logic              CLK_in,
    input  logic              RST_n,
    input  logic              EN,
    input  logic              CFG_valid,
    input  logic [DIV_W-1:0]  CFG_half,
    output logic              CFG_ready,
    input  logic              ERR_clr,
    output logic              CLK_out,
    output logic              TICK,
    output logic              BUSY,
    output logic              ERR
`ifdef FDIV_PCNT_EN
    ,
    output logic [PCNT_W-1:0] PCNT
`endif
);

    fdiv_state_t      r_state;
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_pending;
    logic             r_busy;
    logic             r_err;
    logic             w_accept;
    logic             w_legal;
    logic             w_illegal;
    logic             w_boundary;
    logic             w_run;

    assign CFG_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_accept  = CFG_valid && CFG_ready;
    assign w_legal   = w_accept && (CFG_half != '0);
    assign w_illegal = w_accept && (CFG_half == '0);
    assign w_run     = (r_state != ST_IDLE);
    assign BUSY      = r_busy;
    assign ERR       = r_err;

    fdiv_core #(
        .DIV_W      (DIV_W)
    ) u_core (
        .clk        (CLK_in),
        .rst_n      (RST_n),
        .i_run      (w_run),
        .i_active   (r_active),
        .o_clk      (CLK_out),
        .o_tick     (TICK),
        .o_boundary (w_boundary)
    );

    // Divisor only changes while parked or at a boundary, where the core restarts its count.
    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= ST_IDLE;
            r_active  <= DIV_W'(DEF_HALF);
            r_pending <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_legal) r_active <= CFG_half;
                    if (EN)      r_state  <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_legal) begin
                        r_pending <= CFG_half;
                        r_busy    <= 1'b1;
                        r_state   <= ST_PEND;
                    end else if (!EN) begin
                        r_state   <= ST_STOP;
                    end
                end
                ST_PEND: begin
                    if (w_boundary) begin
                        r_active <= r_pending;
                        r_busy   <= 1'b0;
                        r_state  <= EN ? ST_RUN : ST_IDLE;
                    end
                end
                ST_STOP: begin
                    if (w_boundary) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error; a new illegal offer beats a simultaneous clear.
    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end else if (ERR_clr) begin
            r_err <= 1'b0;
        end
    end

`ifdef FDIV_PCNT_EN
    logic [PCNT_W-1:0] r_pcnt;

    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            r_pcnt <= '0;
        end else if (w_boundary) begin
            r_pcnt <= r_pcnt + PCNT_W'(1);
        end
    end

    assign PCNT = r_pcnt;
`endif

endmodule
